// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer: FSM state, ALU function codes and
// step-word field layout.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StLoad  = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  localparam logic [2:0] FN_HOLD  = 3'b000;
  localparam logic [2:0] FN_MUL   = 3'b001;
  localparam logic [2:0] FN_SHL   = 3'b010;
  localparam logic [2:0] FN_AND   = 3'b011;
  localparam logic [2:0] FN_OR    = 3'b100;
  localparam logic [2:0] FN_PASSB = 3'b101;
  localparam logic [2:0] FN_ADD   = 3'b110;
  localparam logic [2:0] FN_ADDFA = 3'b111;

  // Step word is {func[2:0], data[3:0]}
  localparam int unsigned FuncW   = 3;
  localparam int unsigned DataW   = 4;
  localparam int unsigned StepW   = FuncW + DataW;
  localparam int unsigned DataLsb = 0;
  localparam int unsigned FuncLsb = DataW;

  function automatic logic [FuncW-1:0] step_func(input logic [StepW-1:0] word);
    return word[FuncLsb +: FuncW];
  endfunction

  function automatic logic [DataW-1:0] step_data(input logic [StepW-1:0] word);
    return word[DataLsb +: DataW];
  endfunction

endpackage

// File: rtl/alu_seq_ram.sv
// Program store for the ALU op sequencer: DEPTH x W words, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module alu_seq_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned W     = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Programmable initiator for the 3-bit-function ALU and accumulator register: runs len steps
// from program RAM, two cycles per step. ALU_SEQ_SINGLE_STEP_EN adds a step input gating ISSUE.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [StepW-1:0] prog_data,
  input  logic [AW:0]      len,
  input  logic             start,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [7:0]       alu_result,
  output logic [FuncW-1:0] func_o,
  output logic [DataW-1:0] data_o,
  output logic             load_o,
  output logic [7:0]       result_o,
  output logic [AW-1:0]    pc_o,
  output logic             busy_o,
  output logic             done_o
);

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      len_q, len_d;
  logic [FuncW-1:0] func_q, func_d;
  logic [DataW-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [7:0]       result_q, result_d;

  logic             ram_we;
  logic [AW-1:0]    rd_addr;
  logic [StepW-1:0] rd_word;
  logic [AW:0]      len_clamped;
  logic             last_step;
  logic             step_ok;

`ifdef ALU_SEQ_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign ram_we      = prog_we && (state_q == StIdle);
  // The only reads are step 0 on start and step pc+1 leaving LOAD
  assign rd_addr     = (state_q == StLoad) ? pc_q + AW'(1) : '0;
  assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign last_step   = ({1'b0, pc_q} == len_q - (AW+1)'(1));

  alu_seq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (StepW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    func_d   = func_q;
    data_d   = data_q;
    load_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          pc_d   = '0;
          busy_d = 1'b1;
          if (len == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            func_d  = FN_HOLD;
          end else begin
            len_d   = len_clamped;
            func_d  = step_func(rd_word);
            data_d  = step_data(rd_word);
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (step_ok) begin
          state_d = StLoad;
          load_d  = 1'b1;
        end
      end
      StLoad: begin
        result_d = alu_result;
        if (last_step) begin
          state_d = StDone;
          done_d  = 1'b1;
          func_d  = FN_HOLD;
        end else begin
          pc_d    = pc_q + AW'(1);
          func_d  = step_func(rd_word);
          data_d  = step_data(rd_word);
          state_d = StIssue;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      len_q    <= '0;
      func_q   <= FN_HOLD;
      data_q   <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      func_q   <= func_d;
      data_q   <= data_d;
      load_q   <= load_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

  assign func_o   = func_q;
  assign data_o   = data_q;
  assign load_o   = load_q;
  assign result_o = result_q;
  assign pc_o     = pc_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the ALU and accumulator as responders and checks runs
// against a step-list reference model.
module tb_alu_op_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [6:0] prog_data;
  logic [4:0] len;
  logic       start;
  logic [7:0] alu_result;
  logic [2:0] func_o;
  logic [3:0] data_o;
  logic       load_o;
  logic [7:0] result_o;
  logic [3:0] pc_o;
  logic       busy_o;
  logic       done_o;

  logic [7:0] acc;
  logic [6:0] prog_m [DEPTH];
  logic [7:0] acc_m;
  logic [7:0] result_m;
  int         checks;
  int         passes;

  alu_op_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .len        (len),
    .start      (start),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .alu_result (alu_result),
    .func_o     (func_o),
    .data_o     (data_o),
    .load_o     (load_o),
    .result_o   (result_o),
    .pc_o       (pc_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: A = operand from the sequencer, B = accumulator low nibble
  function automatic logic [7:0] alu_f(input logic [2:0] f, input logic [3:0] a,
                                       input logic [7:0] r);
    logic [7:0] b;
    b = {4'b0, r[3:0]};
    case (f)
      3'b000:  alu_f = r;
      3'b001:  alu_f = {4'b0, a} * b;
      3'b010:  alu_f = b << a;
      3'b011:  alu_f = {4'b0, a} & b;
      3'b100:  alu_f = {4'b0, a} | b;
      3'b101:  alu_f = b;
      3'b110:  alu_f = {4'b0, a} + b;
      default: alu_f = {4'b0, a} + b + 8'd1;
    endcase
  endfunction

  assign alu_result = alu_f(func_o, data_o, acc);

  always @(posedge clk or posedge rst) begin
    if (rst) acc <= 8'h00;
    else if (load_o) acc <= alu_result;
  end

  function automatic int eff_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [63:0] exp_mask(input int e);
    logic [63:0] m;
    m = '0;
    for (int k = 1; k <= e; k++) m[2*k] = 1'b1;
    return m;
  endfunction

  // Reference: apply the first min(len, DEPTH) steps to the accumulator in order
  task automatic model_run(input int l);
    int e;
    e = eff_len(l);
    for (int i = 0; i < e; i++) acc_m = alu_f(prog_m[i][6:4], prog_m[i][3:0], acc_m);
    if (e > 0) result_m = acc_m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    acc_m    = 8'h00;
    result_m = 8'h00;
    tick();
  endtask

  task automatic write_prog(input logic [3:0] a, input logic [6:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    prog_m[a] = d;
  endtask

  // Start a run and observe it cycle by cycle; cycle 1 is the one after the start edge
  task automatic do_run(input int l, input int start_at, input int wr_at,
                        input logic [3:0] wa, input logic [6:0] wd,
                        output int done_cyc, output logic [63:0] lmask,
                        output int busy_cnt, output int pcmax);
    done_cyc = -1;
    lmask    = '0;
    busy_cnt = 0;
    pcmax    = 0;
    len      = 5'(l);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (load_o) lmask[c] = 1'b1;
      if (busy_o) busy_cnt++;
      if (int'(pc_o) > pcmax) pcmax = int'(pc_o);
      start     = (c == start_at);
      prog_we   = (c == wr_at);
      prog_addr = wa;
      prog_data = wd;
      if (done_o) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start   = 1'b0;
    prog_we = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({func_o, data_o, load_o, result_o, pc_o, busy_o, done_o} !== '0)
      $display("FAIL reset_values: got func=%0h data=%0h load=%0b res=%0h pc=%0d busy=%0b done=%0b, want all 0",
               func_o, data_o, load_o, result_o, pc_o, busy_o, done_o);
    else passes++;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, load_o} !== 3'b000)
      $display("FAIL idle_after_reset: got busy/done/load=%b, want 000", {busy_o, done_o, load_o});
    else passes++;
  endtask

  task automatic test_basic_program;
    int dc, bc, pm;
    logic [63:0] lm;
    write_prog(4'd0, {3'b110, 4'd3});
    write_prog(4'd1, {3'b110, 4'd4});
    write_prog(4'd2, {3'b001, 4'd2});
    model_run(3);
    do_run(3, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (dc !== 7) $display("FAIL basic_done_cycle: got %0d, want 7", dc);
    else passes++;
    checks++;
    if (lm !== 64'h54) $display("FAIL basic_load_cycles: got %h, want %h", lm, 64'h54);
    else passes++;
    checks++;
    if (result_o !== 8'h0E || result_o !== result_m)
      $display("FAIL basic_result: got %h, want 0e (model %h)", result_o, result_m);
    else passes++;
    checks++;
    if (acc !== 8'd14) $display("FAIL basic_register: got %0d, want 14", acc);
    else passes++;
    checks++;
    if (bc !== 7 || func_o !== 3'b000)
      $display("FAIL basic_busy_hold: got busy_cycles=%0d func=%0b, want 7 and 000", bc, func_o);
    else passes++;
  endtask

  task automatic test_len_zero;
    int dc, bc, pm;
    logic [63:0] lm;
    model_run(0);
    do_run(0, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (dc !== 1) $display("FAIL len0_done_cycle: got %0d, want 1", dc);
    else passes++;
    checks++;
    if (lm !== '0 || bc !== 1)
      $display("FAIL len0_load_busy: got loads=%h busy_cycles=%0d, want 0 and 1", lm, bc);
    else passes++;
    checks++;
    if (result_o !== result_m) $display("FAIL len0_result: got %h, want %h", result_o, result_m);
    else passes++;
  endtask

  task automatic test_start_while_busy;
    int dc, bc, pm, extra;
    logic [63:0] lm;
    model_run(2);
    do_run(2, 2, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (lm !== 64'h14 || dc !== 5)
      $display("FAIL busy_start_ignored: got loads=%h done=%0d, want 14 and 5", lm, dc);
    else passes++;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_o || busy_o || load_o) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) $display("FAIL busy_start_retrigger: got %0d active cycles, want 0", extra);
    else passes++;
    checks++;
    if (result_o !== result_m) $display("FAIL busy_start_result: got %h, want %h", result_o, result_m);
    else passes++;
  endtask

  task automatic test_write_while_busy;
    int dc, bc, pm;
    logic [63:0] lm;
    do_reset();
    write_prog(4'd0, {3'b110, 4'd5});
    write_prog(4'd1, {3'b110, 4'd2});
    write_prog(4'd2, {3'b100, 4'd8});
    model_run(3);
    do_run(3, 0, 2, 4'd1, {3'b010, 4'd1}, dc, lm, bc, pm);
    checks++;
    if (result_o !== result_m) $display("FAIL busy_write_run1: got %h, want %h", result_o, result_m);
    else passes++;
    do_reset();
    model_run(3);
    do_run(3, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (result_o !== result_m) $display("FAIL busy_write_rerun: got %h, want %h", result_o, result_m);
    else passes++;
  endtask

  task automatic test_reset_midrun;
    int dc, bc, pm;
    logic [63:0] lm;
    len   = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (load_o !== 1'b1 || pc_o !== 4'd1)
      $display("FAIL midrun_in_load2: got load=%b pc=%0d, want 1 and 1", load_o, pc_o);
    else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({load_o, busy_o, result_o, pc_o, done_o} !== '0)
      $display("FAIL midrun_async_reset: got load=%b busy=%b res=%h pc=%0d done=%b, want all 0",
               load_o, busy_o, result_o, pc_o, done_o);
    else passes++;
    #1;
    rst      = 1'b0;
    acc_m    = 8'h00;
    result_m = 8'h00;
    tick();
    model_run(3);
    do_run(3, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (dc !== 7 || result_o !== result_m)
      $display("FAIL midrun_fresh_run: got done=%0d res=%h, want 7 and %h", dc, result_o, result_m);
    else passes++;
  endtask

  task automatic test_full_ram;
    int dc, bc, pm;
    logic [63:0] lm;
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_prog(4'(i), {3'b110, 4'd1});
    model_run(16);
    do_run(16, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (result_o !== 8'h10 || result_o !== result_m)
      $display("FAIL full_result: got %h, want 10 (model %h)", result_o, result_m);
    else passes++;
    checks++;
    if (dc !== 33 || pm !== 15 || pc_o !== 4'd15)
      $display("FAIL full_timing_pc: got done=%0d pcmax=%0d pc=%0d, want 33 15 15", dc, pm, pc_o);
    else passes++;
    do_reset();
    model_run(20);
    do_run(20, 0, 0, 4'd0, 7'd0, dc, lm, bc, pm);
    checks++;
    if (dc !== 33 || result_o !== 8'h10 || lm !== exp_mask(16))
      $display("FAIL clamp_len20: got done=%0d res=%h loads=%h, want 33 10 %h",
               dc, result_o, lm, exp_mask(16));
    else passes++;
  endtask

  task automatic test_random;
    int dc, bc, pm, l, e;
    logic [63:0] lm;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) write_prog(4'(i), 7'($urandom));
      l = int'($urandom_range(0, 20));
      e = eff_len(l);
      model_run(l);
      do_run(l, int'($urandom_range(0, 6)), 0, 4'd0, 7'd0, dc, lm, bc, pm);
      checks++;
      if (dc !== 2*e+1 || lm !== exp_mask(e) || bc !== 2*e+1)
        $display("FAIL rand%0d_timing: len=%0d got done=%0d loads=%h busy=%0d, want %0d %h %0d",
                 it, l, dc, lm, bc, 2*e+1, exp_mask(e), 2*e+1);
      else passes++;
      checks++;
      if (result_o !== result_m || acc !== acc_m)
        $display("FAIL rand%0d_result: len=%0d got res=%h acc=%h, want %h %h",
                 it, l, result_o, acc, result_m, acc_m);
      else passes++;
    end
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    len       = '0;
    start     = 1'b0;
    acc_m     = 8'h00;
    result_m  = 8'h00;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = '0;
    test_reset();
    test_basic_program();
    test_len_zero();
    test_start_while_busy();
    test_write_while_busy();
    test_reset_midrun();
    test_full_ram();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Programmable initiator that drives the existing 3-bit-function ALU and 8-bit accumulator register in place of the push-button/switch front end. It holds a small program RAM of {func, data} steps. On a start pulse it issues each step's function and 4-bit operand to the ALU, pulses the register load enable, and captures the result. It pulses done after the last step; the ALU and register are its responders.

Parameters:
- DEPTH, 16, number of program steps held in RAM.
- AW, 4, address/length width; DEPTH == 2**AW.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program RAM write strobe.
- prog_addr  in  AW  write address.
- prog_data  in  7  {func[2:0], data[3:0]} step word.
- len  in  AW+1  number of steps to run (0..DEPTH); sampled on accepted start.
- start  in  1  run request; one-cycle pulse or level.
- alu_result  in  8  combinational ALU output.
- func_o  out  3  ALU function select.
- data_o  out  4  ALU A operand.
- load_o  out  1  accumulator register load enable.
- result_o  out  8  last captured ALU result.
- pc_o  out  AW  current step index.
- busy_o  out  1  high in ISSUE/LOAD/DONE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high; Clock and Reset only): state=IDLE; func_o=3'b000 (ALU hold); data_o=0; load_o=0; result_o=0; pc_o=0; busy_o=0; done_o=0. RAM contents are not reset.
- RAM writes: synchronous, accepted only in IDLE. prog_we while busy is ignored.
- FSM states: IDLE, ISSUE, LOAD, DONE.
  - IDLE, start=1, len>0: latch len; pc=0; func_o/data_o <= RAM[0]; go to ISSUE.
  - IDLE, start=1, len=0: go straight to DONE; no load pulse.
  - ISSUE: one settle cycle; load_o=0; go to LOAD.
  - LOAD: load_o=1 for exactly this cycle; result_o <= alu_result at the end edge.
    - If pc==len-1: go to DONE.
    - Else: pc+1; func_o/data_o <= RAM[pc+1]; go to ISSUE.
  - DONE: done_o=1 for one cycle; func_o=3'b000; go to IDLE.
- Latency: a start accepted at edge 0 gives done_o high 2*len+1 cycles later. Each step is exactly 2 cycles.
- start while busy: ignored; no queueing. A held start re-triggers only once the FSM is back in IDLE.
- len > DEPTH: clamped to DEPTH. pc never wraps; a run stops at DEPTH-1.
- Reset mid-run: immediate return to reset values; load_o drops asynchronously.
- func_o/data_o are registered and stable across ISSUE and LOAD.

Optional Feature:
- Macro: ALU_SEQ_SINGLE_STEP_EN.
- When defined: adds input port step. ISSUE leaves for LOAD only in a cycle where step=1; otherwise it stays in ISSUE with outputs held.
- When undefined: no step port; ISSUE always lasts exactly one cycle.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state enum;
  - ALU function constants FN_HOLD=000, FN_MUL=001, FN_SHL=010, FN_AND=011, FN_OR=100, FN_PASSB=101, FN_ADD=110, FN_ADDFA=111;
  - step-word field offsets.
- One natural sub-module: alu_seq_ram, DEPTH x 7 storage with a synchronous write port and an asynchronous read port.

Test Plan:
- Bench models the ALU and an 8-bit register whose B input is reg[3:0].
- Program {ADD,3},{ADD,4},{MUL,2}, len=3, start -> load_o pulses at cycles 2,4,6; register 3, 7, 14; result_o=8'h0E; done_o at cycle 7.
- len=0, start -> done_o the next cycle; load_o never asserted; busy_o high for 1 cycle.
- Start pulse during step 1 of a len=2 run -> ignored; exactly 2 load pulses; single done_o.
- prog_we to addr 1 with data {SHL,1} while busy -> RAM unchanged; rerun gives the original result.
- Reset asserted during LOAD of step 2 -> load_o, busy_o, result_o, pc_o are 0 immediately; a fresh start then runs normally.
- len=16 (full RAM) with all {ADD,1} from register 0 -> result_o=8'h10 after 33 cycles; pc_o peaks at 15, no wrap. With ALU_SEQ_SINGLE_STEP_EN defined, no step pulses -> stalls in ISSUE indefinitely.
